// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between an I-cache and a
// D-cache. One transaction at a time: IDLE -> SERVE_I/SERVE_D -> DONE -> IDLE.
// Optional feature: define PMEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise the D-cache always wins a contest.
module pmem_arbiter (
   input  logic         clk,
   input  logic         reset,
   input  logic         icache_pmem_read,
   input  logic [15:0]  icache_pmem_address,
   output logic [127:0] icache_pmem_rdata,
   output logic         icache_pmem_resp,
   input  logic         dcache_pmem_read,
   input  logic         dcache_pmem_write,
   input  logic [15:0]  dcache_pmem_address,
   input  logic [127:0] dcache_pmem_wdata,
   output logic [127:0] dcache_pmem_rdata,
   output logic         dcache_pmem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t        state, state_next;
   logic [15:0]   addr_q;
   logic [127:0]  wdata_q;
   logic [127:0]  line_q;
   logic          write_q;
   logic          grant_d_q;
   logic          i_req, d_req, any_req, pick_d, serving, start;

   assign i_req   = icache_pmem_read;
   assign d_req   = dcache_pmem_read | dcache_pmem_write;
   assign any_req = i_req | d_req;
   assign start   = (state == IDLE) && any_req;
   assign serving = (state == SERVE_I) || (state == SERVE_D);

`ifdef PMEM_ARBITER_RR_EN
   logic last_d_q;

   // Contest goes to whichever requester was not granted last
   always_comb begin
      pick_d = d_req & (~i_req | ~last_d_q);
   end

   // Grant history: reset to I-cache so the first contest favours the D-cache
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b0;
      end else if (start) begin
         last_d_q <= pick_d;
      end
   end
`else
   // Fixed priority: D-cache wins whenever it requests
   always_comb begin
      pick_d = d_req;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (any_req) state_next = pick_d ? SERVE_D : SERVE_I;
         SERVE_I,
         SERVE_D: if (pmem_resp) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latch the granted transaction at grant time; capture the line on pmem_resp
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         line_q    <= '0;
         write_q   <= 1'b0;
         grant_d_q <= 1'b0;
      end else begin
         if (start) begin
            grant_d_q <= pick_d;
            addr_q    <= pick_d ? dcache_pmem_address : icache_pmem_address;
            wdata_q   <= pick_d ? dcache_pmem_wdata : '0;
            // read+write together counts as a write
            write_q   <= pick_d & dcache_pmem_write;
         end
         if (serving && pmem_resp) begin
            line_q <= pmem_rdata;
         end
      end
   end

   // Outputs: memory bus only live while serving, resp only in DONE
   always_comb begin
      pmem_read         = serving & ~write_q;
      pmem_write        = serving & write_q;
      pmem_address      = serving ? addr_q : '0;
      pmem_wdata        = serving ? wdata_q : '0;
      icache_pmem_resp  = (state == DONE) & ~grant_d_q;
      dcache_pmem_resp  = (state == DONE) & grant_d_q;
      icache_pmem_rdata = line_q;
      dcache_pmem_rdata = line_q;
   end

endmodule
